// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, writeback source encodings and
// the EX/MEM latch state enum.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MEM = 2'd1;
  localparam logic [1:0] MEMTOREG_LUI = 2'd2;
  localparam logic [1:0] MEMTOREG_NPC = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } exmem_state_t;

endpackage

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: latches execute results, issues the data-cache
// request and holds it until dhit, and provides flush bubbles and sticky halt.
module ex_mem_latch
  import cpu_types_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  input  logic         stall,
  input  logic         flush,
  input  logic         regwrite_in,
  input  logic [1:0]   memtoreg_in,
  input  logic         dmemREN_in,
  input  logic         dmemWEN_in,
  input  logic         halt_in,
  input  regbits_t     wsel_in,
  input  word_t        NPC_in,
  input  word_t        aluout_in,
  input  word_t        rdat_two_in,
  input  word_t        uppersixteen_in,
  input  logic         dhit,
  input  word_t        dmemload,
  output logic         regwrite_out,
  output logic [1:0]   memtoreg_out,
  output regbits_t     wsel_out,
  output word_t        NPC_out,
  output word_t        aluout_out,
  output word_t        uppersixteen_out,
  output logic         halt_out,
  output logic         dmemREN,
  output logic         dmemWEN,
  output word_t        dmemaddr,
  output word_t        dmemstore,
  output word_t        dmemload_out,
  output logic         mem_busy,
  output exmem_state_t state_dbg
);

  exmem_state_t state, next_state;
  logic         ren_r, wen_r;
  logic         cap;

  // Handshake: the request is valid while state==REQ; dhit is the ready.
  // mem_busy is combinational so a dhit releases the upstream stall in the
  // same cycle and the next instruction can be captured on that edge.
  assign mem_busy  = (state == REQ) & ~dhit;
  assign cap       = ~stall & ~mem_busy & (state != HALTED);
  assign dmemREN   = (state == REQ) & ren_r;
  assign dmemWEN   = (state == REQ) & wen_r;
  assign dmemaddr  = aluout_out;
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    if (cap) begin
      if (flush)                          next_state = IDLE;
      else if (halt_in)                   next_state = HALTED;
      else if (dmemREN_in | dmemWEN_in)   next_state = REQ;
      else                                next_state = IDLE;
    end else if ((state == REQ) && dhit) begin
      // completed under stall: drop the request, hold everything else
      next_state = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state            <= IDLE;
      regwrite_out     <= 1'b0;
      memtoreg_out     <= 2'b00;
      wsel_out         <= '0;
      NPC_out          <= '0;
      aluout_out       <= '0;
      uppersixteen_out <= '0;
      halt_out         <= 1'b0;
      dmemstore        <= '0;
      dmemload_out     <= '0;
      ren_r            <= 1'b0;
      wen_r            <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == REQ) && dhit) begin
        if (ren_r) dmemload_out <= dmemload;
        ren_r <= 1'b0;
        wen_r <= 1'b0;
      end
      // a capture in the same cycle overrides the cleared request bits
      if (cap) begin
        if (flush) begin
          regwrite_out     <= 1'b0;
          memtoreg_out     <= 2'b00;
          wsel_out         <= '0;
          NPC_out          <= '0;
          aluout_out       <= '0;
          uppersixteen_out <= '0;
          halt_out         <= 1'b0;
          dmemstore        <= '0;
          ren_r            <= 1'b0;
          wen_r            <= 1'b0;
        end else begin
          regwrite_out     <= regwrite_in;
          memtoreg_out     <= memtoreg_in;
          wsel_out         <= wsel_in;
          NPC_out          <= NPC_in;
          aluout_out       <= aluout_in;
          uppersixteen_out <= uppersixteen_in;
          halt_out         <= halt_in;
          dmemstore        <= rdat_two_in;
          ren_r            <= dmemREN_in;
          wen_r            <= dmemWEN_in;
        end
      end
    end
  end

endmodule
